// File: rtl/apb_bridge.sv
// APB master bridge for the processor memory port: one transfer register, one
// pending request slot, wait-state handling and a PREADY timeout abort.
module apb_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        req_en,
    input  logic        req_write,
    input  logic        req_sel,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        req_drop,
    output logic        busy,
    output logic [7:0]  paddr,
    output logic [1:0]  psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
    localparam logic TMO_EN = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    function automatic logic [1:0] onehot_sel(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [7:0]     cur_addr_r;
    logic           cur_write_r;
    logic           cur_sel_r;
    logic [31:0]    cur_wdata_r;
    logic           pend_v_r;
    logic [7:0]     pend_addr_r;
    logic           pend_write_r;
    logic           pend_sel_r;
    logic [31:0]    pend_wdata_r;
    logic [1:0]     psel_r;
    logic           penable_r;
    logic [31:0]    rdata_r;
    logic           rsp_valid_r;
    logic           rsp_err_r;
    logic           req_drop_r;
    logic           busy_r;

    logic           launch_pend_s;
    logic           launch_req_s;
    logic           finish_s;
    logic           err_s;
    logic           rd_upd_s;
    logic           timeout_s;
    logic           pend_set_s;
    logic           drop_s;
    logic           pend_v_nxt_s;
    logic           sel_nxt_s;

    // Next-state, launch selection and pending-slot capture decisions.
    always_comb begin
        state_nxt_s   = state_r;
        launch_pend_s = 1'b0;
        launch_req_s  = 1'b0;
        finish_s      = 1'b0;
        err_s         = 1'b0;
        rd_upd_s      = 1'b0;
        pend_set_s    = 1'b0;
        drop_s        = 1'b0;
        timeout_s     = TMO_EN & (cnt_r == TMO);

        case (state_r)
            IDLE: begin
                if (pend_v_r) begin
                    launch_pend_s = 1'b1;
                end else if (req_en) begin
                    launch_req_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = ACCESS;
            end
            ACCESS: begin
                if (pready || timeout_s) begin
                    finish_s = 1'b1;
                    err_s    = pready ? pslverr : 1'b1;
                    rd_upd_s = pready & ~cur_write_r & ~pslverr;
                    if (pend_v_r) begin
                        launch_pend_s = 1'b1;
                    end else if (req_en) begin
                        launch_req_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (launch_pend_s || launch_req_s) begin
            state_nxt_s = SETUP;
        end else begin
            state_nxt_s = state_nxt_s;
        end

        // A launch from the slot frees it in the same cycle, so a new request can refill it.
        if (req_en && !launch_req_s) begin
            if (!pend_v_r || launch_pend_s) begin
                pend_set_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            pend_set_s = 1'b0;
        end

        pend_v_nxt_s = pend_set_s ? 1'b1 : (launch_pend_s ? 1'b0 : pend_v_r);
        sel_nxt_s    = launch_pend_s ? pend_sel_r : (launch_req_s ? req_sel : cur_sel_r);
    end

    // FSM state and saturating ACCESS wait counter.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == SETUP) begin
                cnt_r <= {CW{1'b0}};
            end else if ((state_r == ACCESS) && !pready && (cnt_r != {CW{1'b1}})) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Transfer register: loaded only on launch so APB fields hold through ACCESS and IDLE.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cur_addr_r  <= 8'h00;
            cur_write_r <= 1'b0;
            cur_sel_r   <= 1'b0;
            cur_wdata_r <= 32'h0000_0000;
        end else if (launch_pend_s) begin
            cur_addr_r  <= pend_addr_r;
            cur_write_r <= pend_write_r;
            cur_sel_r   <= pend_sel_r;
            cur_wdata_r <= pend_wdata_r;
        end else if (launch_req_s) begin
            cur_addr_r  <= req_addr;
            cur_write_r <= req_write;
            cur_sel_r   <= req_sel;
            cur_wdata_r <= req_wdata;
        end
    end

    // Single-entry pending request slot.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pend_v_r     <= 1'b0;
            pend_addr_r  <= 8'h00;
            pend_write_r <= 1'b0;
            pend_sel_r   <= 1'b0;
            pend_wdata_r <= 32'h0000_0000;
        end else begin
            pend_v_r <= pend_v_nxt_s;
            if (pend_set_s) begin
                pend_addr_r  <= req_addr;
                pend_write_r <= req_write;
                pend_sel_r   <= req_sel;
                pend_wdata_r <= req_wdata;
            end
        end
    end

    // Registered APB control, response pulses, read data and busy flag.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            psel_r      <= 2'b00;
            penable_r   <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            req_drop_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            psel_r      <= (state_nxt_s != IDLE) ? onehot_sel(sel_nxt_s) : 2'b00;
            penable_r   <= (state_nxt_s == ACCESS);
            rsp_valid_r <= finish_s;
            rsp_err_r   <= finish_s & err_s;
            req_drop_r  <= drop_s;
            busy_r      <= (state_nxt_s != IDLE) | pend_v_nxt_s;
            if (rd_upd_s) begin
                rdata_r <= prdata;
            end
        end
    end

    assign paddr     = cur_addr_r;
    assign pwrite    = cur_write_r;
    assign pwdata    = cur_wdata_r;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign rdata     = rdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign req_drop  = req_drop_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_apb_bridge.sv
// Self-checking bench for apb_bridge: scenario tasks with inline checks plus a
// response scoreboard fed when requests are issued.
module tb_apb_bridge;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        req_en;
    logic        req_write;
    logic        req_sel;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic        req_drop;
    logic        busy;
    logic [7:0]  paddr;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];

    apb_bridge #(.TIMEOUT(4)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .req_en(req_en), .req_write(req_write), .req_sel(req_sel),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .req_drop(req_drop), .busy(busy),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 Clock = ~Clock;

    // Scoreboard: every response pulse must match the oldest expected {err, rdata}.
    always @(negedge Clock) begin
        if (Resetn && rsp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: rsp_valid with no outstanding request, err=%b rdata=%h", rsp_err, rdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({rsp_err, rdata} !== e) begin
                    bad++;
                    $display("FAIL sb_rsp: got err=%b rdata=%h, want err=%b rdata=%h", rsp_err, rdata, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge Clock);
    endtask

    task automatic drive_req(input logic w, input logic s, input logic [7:0] a, input logic [31:0] d);
        req_en    = 1'b1;
        req_write = w;
        req_sel   = s;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        req_en = 1'b0; req_write = 1'b0; req_sel = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        #1;
        total++;
        if ({rdata, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, req_drop, busy} !== 80'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rdata=%h psel=%b paddr=%h pwdata=%h busy=%b, want all 0", rdata, psel, paddr, pwdata, busy);
        end
        tick; tick;
        Resetn = 1'b1;
        tick; tick;
        total++;
        if ({busy, psel, penable, rsp_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b psel=%b penable=%b rsp_valid=%b, want 0", busy, psel, penable, rsp_valid);
        end
    endtask

    task automatic test_read_zero_wait;
        drive_req(1'b0, 1'b0, 8'h12, 32'h0);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        tick;                               // N+1 SETUP
        req_en = 1'b0;
        total++;
        if ({psel, penable, paddr, pwrite} !== {2'b01, 1'b0, 8'h12, 1'b0}) begin
            bad++;
            $display("FAIL rd_setup: got psel=%b penable=%b paddr=%h pwrite=%b, want 01 0 12 0", psel, penable, paddr, pwrite);
        end
        prdata = 32'hDEADBEEF; pready = 1'b1;
        tick;                               // N+2 ACCESS
        total++;
        if ({psel, penable, rsp_valid} !== {2'b01, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rd_access: got psel=%b penable=%b rsp_valid=%b, want 01 1 0", psel, penable, rsp_valid);
        end
        tick;                               // N+3 response
        pready = 1'b0;
        total++;
        if ({rsp_valid, rsp_err, rdata, busy, psel, penable} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL rd_resp: got valid=%b err=%b rdata=%h busy=%b psel=%b, want 1 0 deadbeef 0 00", rsp_valid, rsp_err, rdata, busy, psel);
        end
        tick;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_pulse: got rsp_valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_write_wait;
        drive_req(1'b1, 1'b1, 8'h40, 32'h0000_00A5);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        prdata = 32'h1111_1111;
        tick;                               // SETUP
        req_en = 1'b0;
        total++;
        if ({psel, pwrite, penable} !== {2'b10, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL wr_setup: got psel=%b pwrite=%b penable=%b, want 10 1 0", psel, pwrite, penable);
        end
        for (int i = 0; i < 4; i++) begin
            tick;                           // ACCESS cycle i
            total++;
            if ({penable, psel, paddr, pwdata, rsp_valid} !== {1'b1, 2'b10, 8'h40, 32'h0000_00A5, 1'b0}) begin
                bad++;
                $display("FAIL wr_hold%0d: got penable=%b psel=%b paddr=%h pwdata=%h valid=%b", i, penable, psel, paddr, pwdata, rsp_valid);
            end
            pready = (i == 3);
        end
        tick;
        pready = 1'b0;
        total++;
        if ({rsp_valid, rsp_err, rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL wr_resp: got valid=%b err=%b rdata=%h, want 1 0 deadbeef", rsp_valid, rsp_err, rdata);
        end
    endtask

    task automatic test_slverr;
        drive_req(1'b0, 1'b0, 8'h20, 32'h0);
        exp_q.push_back({1'b1, 32'hDEADBEEF});
        tick;
        req_en = 1'b0;
        prdata = 32'h5555_5555; pready = 1'b1; pslverr = 1'b1;
        tick;
        tick;
        pready = 1'b0; pslverr = 1'b0;
        total++;
        if ({rsp_valid, rsp_err, rdata} !== {1'b1, 1'b1, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL slverr_resp: got valid=%b err=%b rdata=%h, want 1 1 deadbeef", rsp_valid, rsp_err, rdata);
        end
    endtask

    task automatic test_timeout;
        drive_req(1'b0, 1'b1, 8'h7F, 32'h0);
        exp_q.push_back({1'b1, 32'hDEADBEEF});
        prdata = 32'h2222_2222; pready = 1'b0;
        tick;                               // SETUP
        req_en = 1'b0;
        tick;                               // ACCESS entry A
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({penable, rsp_valid} !== 2'b10) begin
                bad++;
                $display("FAIL tmo_wait%0d: got penable=%b rsp_valid=%b, want 1 0", i, penable, rsp_valid);
            end
            tick;
        end
        total++;                            // A+5
        if ({rsp_valid, rsp_err, rdata, psel, penable, busy} !== {1'b1, 1'b1, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL tmo_abort: got valid=%b err=%b rdata=%h psel=%b penable=%b busy=%b", rsp_valid, rsp_err, rdata, psel, penable, busy);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int n_rsp;
        n_rsp = 0;
        drive_req(1'b0, 1'b0, 8'h01, 32'h0);  // N
        exp_q.push_back({1'b0, 32'h0000_00A1});
        pready = 1'b0;
        tick; n_rsp += int'(rsp_valid);       // N+1
        drive_req(1'b0, 1'b0, 8'h02, 32'h0);
        exp_q.push_back({1'b0, 32'h0000_00A2});
        tick; n_rsp += int'(rsp_valid);       // N+2
        drive_req(1'b0, 1'b0, 8'h03, 32'h0);
        tick; n_rsp += int'(rsp_valid);       // N+3
        req_en = 1'b0;
        total++;
        if ({req_drop, busy} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_drop: got req_drop=%b busy=%b, want 1 1", req_drop, busy);
        end
        prdata = 32'h0000_00A1; pready = 1'b1;
        tick; n_rsp += int'(rsp_valid);       // N+4 second SETUP
        total++;
        if ({rsp_valid, psel, penable, paddr, req_drop} !== {1'b1, 2'b01, 1'b0, 8'h02, 1'b0}) begin
            bad++;
            $display("FAIL b2b_setup: got valid=%b psel=%b penable=%b paddr=%h drop=%b", rsp_valid, psel, penable, paddr, req_drop);
        end
        prdata = 32'h0000_00A2;
        tick; n_rsp += int'(rsp_valid);       // N+5 ACCESS
        total++;
        if ({penable, paddr} !== {1'b1, 8'h02}) begin
            bad++;
            $display("FAIL b2b_access: got penable=%b paddr=%h, want 1 02", penable, paddr);
        end
        tick; n_rsp += int'(rsp_valid);       // N+6
        pready = 1'b0;
        total++;
        if ({rdata, busy} !== {32'h0000_00A2, 1'b0}) begin
            bad++;
            $display("FAIL b2b_done: got rdata=%h busy=%b, want 000000a2 0", rdata, busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick; n_rsp += int'(rsp_valid);
        end
        total++;
        if (n_rsp != 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d rsp_valid pulses, want 2", n_rsp);
        end
    endtask

    task automatic test_reset_mid;
        drive_req(1'b1, 1'b1, 8'h33, 32'h0000_0077);
        pready = 1'b0;
        tick;                               // SETUP
        drive_req(1'b1, 1'b0, 8'h34, 32'h0000_0078);
        tick;                               // ACCESS, slot full
        req_en = 1'b0;
        total++;
        if ({busy, penable} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid_pre: got busy=%b penable=%b, want 1 1", busy, penable);
        end
        Resetn = 1'b0;
        #1;
        total++;
        if ({rdata, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, req_drop, busy} !== 80'h0) begin
            bad++;
            $display("FAIL rstmid_clear: got rdata=%h psel=%b paddr=%h pwdata=%h busy=%b, want all 0", rdata, psel, paddr, pwdata, busy);
        end
        tick; tick;
        Resetn = 1'b1;
        tick; tick;
        total++;
        if ({busy, rsp_valid, psel} !== 4'b0) begin
            bad++;
            $display("FAIL rstmid_idle: got busy=%b rsp_valid=%b psel=%b, want 0", busy, rsp_valid, psel);
        end
        drive_req(1'b0, 1'b0, 8'h05, 32'h0);
        exp_q.push_back({1'b0, 32'hCAFE_0005});
        tick;
        req_en = 1'b0;
        total++;
        if ({psel, penable, paddr} !== {2'b01, 1'b0, 8'h05}) begin
            bad++;
            $display("FAIL rstmid_setup: got psel=%b penable=%b paddr=%h, want 01 0 05", psel, penable, paddr);
        end
        prdata = 32'hCAFE_0005; pready = 1'b1;
        tick;
        tick;
        pready = 1'b0;
        total++;
        if ({rsp_valid, rdata} !== {1'b1, 32'hCAFE_0005}) begin
            bad++;
            $display("FAIL rstmid_after: got valid=%b rdata=%h, want 1 cafe0005", rsp_valid, rdata);
        end
        tick; tick;
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d outstanding responses, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
